// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder
//
// Memory-side slave for the core's load/store port. Accepts one valid/ready
// request at a time, waits a fixed number of cycles, performs the access on a
// little-endian word store with byte enables, and holds the response until
// the requester takes it. Misaligned or out-of-range addresses return an
// error and never touch storage.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous reset, active-low
//   req_valid  in   request present
//   req_ready  out  responder idle and able to accept a request
//   req_we     in   1 = write, 0 = read
//   req_addr   in   byte address
//   req_wdata  in   write data
//   req_be     in   byte enables, bit i covers data[8i+7:8i]
//   rsp_valid  out  response present
//   rsp_ready  in   requester accepts response
//   rsp_rdata  out  read data (0 for writes and errors)
//   rsp_err    out  access error flag
// -----------------------------------------------------------------------------
module data_mem_responder #(
   parameter int ADDRESS_WIDTH  = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int MEM_ADDR_WIDTH = 8,
   parameter int LATENCY        = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic                      req_we,
   input  logic [ADDRESS_WIDTH-1:0]  req_addr,
   input  logic [DATA_WIDTH-1:0]     req_wdata,
   input  logic [DATA_WIDTH/8-1:0]   req_be,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [DATA_WIDTH-1:0]     rsp_rdata,
   output logic                      rsp_err
);

   localparam int BE_WIDTH   = DATA_WIDTH / 8;
   localparam int WORD_DEPTH = 2 ** (MEM_ADDR_WIDTH - 2);
   localparam int CNT_WIDTH  = $clog2(LATENCY) + 1;

   localparam logic [CNT_WIDTH-1:0] CNT_LOAD = CNT_WIDTH'(LATENCY - 1);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   // Reject unsupported configurations at elaboration.
   if (LATENCY < 1) begin : g_bad_latency
      $error("data_mem_responder: LATENCY must be at least 1");
   end
   if (DATA_WIDTH != 32) begin : g_bad_data_width
      $error("data_mem_responder: DATA_WIDTH must be 32");
   end
   if (MEM_ADDR_WIDTH < 3 || MEM_ADDR_WIDTH >= ADDRESS_WIDTH) begin : g_bad_mem_width
      $error("data_mem_responder: MEM_ADDR_WIDTH must be in [3, ADDRESS_WIDTH-1]");
   end

   logic [1:0]                r_state;
   logic [CNT_WIDTH-1:0]      r_cnt;
   logic                      r_we;
   logic [ADDRESS_WIDTH-1:0]  r_addr;
   logic [DATA_WIDTH-1:0]     r_wdata;
   logic [BE_WIDTH-1:0]       r_be;
   logic [DATA_WIDTH-1:0]     r_rdata;
   logic                      r_err;
   logic [DATA_WIDTH-1:0]     r_mem [WORD_DEPTH];

   logic                      w_accept;
   logic                      w_access;
   logic                      w_err;
   logic [MEM_ADDR_WIDTH-3:0] w_word_idx;
   logic [DATA_WIDTH-1:0]     w_be_mask;

   // Gate with rst so the port reads 0 for the whole reset interval.
   assign req_ready  = (r_state == S_IDLE) && rst;
   assign rsp_valid  = (r_state == S_RESP);
   assign rsp_rdata  = r_rdata;
   assign rsp_err    = r_err;

   assign w_accept   = req_valid && req_ready;
   assign w_access   = (r_state == S_BUSY) && (r_cnt == '0);
   assign w_word_idx = r_addr[MEM_ADDR_WIDTH-1:2];
   assign w_err      = (r_addr[1:0] != 2'b00) ||
                       (r_addr[ADDRESS_WIDTH-1:MEM_ADDR_WIDTH] != '0);

   // NOTE: every signal written in always_comb gets a default first, so no
   // path through the block leaves it unassigned and no latch is inferred.
   always_comb begin
      w_be_mask = '0;
      for (int i = 0; i < BE_WIDTH; i++) begin
         w_be_mask[8*i +: 8] = {8{r_be[i]}};
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_be    <= '0;
         r_rdata <= '0;
         r_err   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_we    <= req_we;
                  r_addr  <= req_addr;
                  r_wdata <= req_wdata;
                  r_be    <= req_be;
                  r_cnt   <= CNT_LOAD;
                  r_state <= S_BUSY;
               end
            end
            S_BUSY: begin
               if (r_cnt != '0) begin
                  r_cnt <= r_cnt - CNT_ONE;
               end else begin
                  // Writes and errors return zero data; reads mask off
                  // disabled bytes.
                  r_rdata <= (r_we || w_err) ? '0 : (r_mem[w_word_idx] & w_be_mask);
                  r_err   <= w_err;
                  r_state <= S_RESP;
               end
            end
            S_RESP: begin
               if (rsp_ready) begin
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // NOTE: storage carries no reset; contents survive rst and are only
   // defined once written. A reset mid-transaction forces r_state to IDLE
   // asynchronously, so an uncommitted write can never reach this block.
   always_ff @(posedge clk) begin
      if (w_access && r_we && !w_err) begin
         for (int i = 0; i < BE_WIDTH; i++) begin
            if (r_be[i]) begin
               r_mem[w_word_idx][8*i +: 8] <= r_wdata[8*i +: 8];
            end
         end
      end
   end

endmodule

// File: tb/tb_data_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_data_mem_responder
//
// Self-checking bench for data_mem_responder. A word-array model computes the
// expected response for each transaction from the address/byte-enable rules;
// directed scenarios are followed by randomized traffic.
// -----------------------------------------------------------------------------
module tb_data_mem_responder;

   localparam int LATENCY = 2;
   localparam int TIMEOUT = 20;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [3:0]  req_be;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   int n_tests = 0;
   int n_fail  = 0;

   logic [31:0] mdl [64];

   always #5 clk = ~clk;

   data_mem_responder #(
      .ADDRESS_WIDTH (32),
      .DATA_WIDTH    (32),
      .MEM_ADDR_WIDTH(8),
      .LATENCY       (LATENCY)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .req_valid(req_valid),
      .req_ready(req_ready),
      .req_we   (req_we),
      .req_addr (req_addr),
      .req_wdata(req_wdata),
      .req_be   (req_be),
      .rsp_valid(rsp_valid),
      .rsp_ready(rsp_ready),
      .rsp_rdata(rsp_rdata),
      .rsp_err  (rsp_err)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Reference behaviour: 64 words of 4 bytes, addresses >= 256 or not a
   // multiple of 4 are errors.
   task automatic model_access(input logic we, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [3:0] be,
                               output logic [31:0] exp_rdata, output logic exp_err);
      int w;
      exp_rdata = 32'h0;
      exp_err   = (addr % 4 != 0) || (addr >= 32'd256);
      w         = int'(addr / 4) % 64;
      if (!exp_err) begin
         for (int b = 0; b < 4; b++) begin
            if (be[b]) begin
               if (we) mdl[w][8*b +: 8] = wdata[8*b +: 8];
               else    exp_rdata[8*b +: 8] = mdl[w][8*b +: 8];
            end
         end
      end
   endtask

   // Request fields must already be driven with req_valid=1. Returns at a
   // negedge with the responder back in IDLE.
   task automatic complete_txn(input int hold, output logic [31:0] obs_rdata);
      logic [31:0] exp_rdata;
      logic        exp_err;
      int          n;
      int          k;
      string       id;
      id = $sformatf("%s@%08h", req_we ? "wr" : "rd", req_addr);
      model_access(req_we, req_addr, req_wdata, req_be, exp_rdata, exp_err);
      obs_rdata = 32'hx;
      n = 0;
      while (!req_ready && n < TIMEOUT) begin
         @(negedge clk);
         n++;
      end
      if (n >= TIMEOUT) begin
         check({id, " accept_timeout"}, 32'(n), 32'(0));
         req_valid = 1'b0;
         return;
      end
      @(negedge clk);
      req_valid = 1'b0;
      k = 0;
      while (!rsp_valid && k < TIMEOUT) begin
         @(negedge clk);
         k++;
      end
      check({id, " latency"}, 32'(k), 32'(LATENCY));
      check({id, " rdata"}, rsp_rdata, exp_rdata);
      check({id, " err"}, 32'(rsp_err), 32'(exp_err));
      obs_rdata = rsp_rdata;
      // Backpressure with a competing request that must not be taken.
      for (int h = 0; h < hold; h++) begin
         req_valid = 1'b1;
         req_we    = 1'b0;
         req_addr  = 32'($urandom_range(0, 63) * 4);
         req_be    = 4'hF;
         @(negedge clk);
         check({id, " hold_valid"}, 32'(rsp_valid), 32'(1));
         check({id, " hold_rdata"}, rsp_rdata, exp_rdata);
         check({id, " hold_err"}, 32'(rsp_err), 32'(exp_err));
         check({id, " hold_req_ready"}, 32'(req_ready), 32'(0));
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      rsp_ready = 1'b0;
      check({id, " post_rsp_valid"}, 32'(rsp_valid), 32'(0));
      check({id, " post_req_ready"}, 32'(req_ready), 32'(1));
   endtask

   task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] be, input int hold, output logic [31:0] obs_rdata);
      @(negedge clk);
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = addr;
      req_wdata = wdata;
      req_be    = be;
      complete_txn(hold, obs_rdata);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] obs;
      logic [31:0] addr;
      int          sel;

      // 1: reset holds the port closed even with a request waiting.
      rst       = 1'b0;
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_addr  = 32'h0;
      req_wdata = 32'h0BADF00D;
      req_be    = 4'hF;
      rsp_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check($sformatf("rst_req_ready[%0d]", i), 32'(req_ready), 32'(0));
         check($sformatf("rst_rsp_valid[%0d]", i), 32'(rsp_valid), 32'(0));
         check($sformatf("rst_rdata[%0d]", i), rsp_rdata, 32'h0);
         check($sformatf("rst_err[%0d]", i), 32'(rsp_err), 32'(0));
      end
      rst = 1'b1;
      #1;
      check("release_req_ready", 32'(req_ready), 32'(1));
      complete_txn(0, obs);

      // Fill the whole store so every later read has a defined value.
      for (int w = 1; w < 64; w++) begin
         txn(1'b1, 32'(w * 4), $urandom, 4'hF, 0, obs);
      end

      // 2: full-word write then read back.
      txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, obs);
      check("t2_write_rdata", obs, 32'h0);
      txn(1'b0, 32'h10, 32'h0, 4'hF, 0, obs);
      check("t2_read", obs, 32'hDEADBEEF);

      // 3: partial write and masked reads.
      txn(1'b1, 32'h10, 32'h0000AA00, 4'b0010, 0, obs);
      txn(1'b0, 32'h10, 32'h0, 4'hF, 0, obs);
      check("t3_read_full", obs, 32'hDEADAAEF);
      txn(1'b0, 32'h10, 32'h0, 4'b0011, 0, obs);
      check("t3_read_low", obs, 32'h0000AAEF);

      // 4: five cycles of backpressure.
      txn(1'b0, 32'h10, 32'h0, 4'hF, 5, obs);
      check("t4_read", obs, 32'hDEADAAEF);

      // 5: errors leave storage alone; be=0 write is a harmless no-op.
      txn(1'b1, 32'h0, 32'h5A5A1234, 4'hF, 0, obs);
      txn(1'b0, 32'h13, 32'h0, 4'hF, 0, obs);
      txn(1'b1, 32'h100, 32'hFFFFFFFF, 4'hF, 0, obs);
      txn(1'b1, 32'h0, 32'hFFFFFFFF, 4'h0, 0, obs);
      txn(1'b0, 32'h0, 32'h0, 4'hF, 0, obs);
      check("t5_read_unchanged", obs, 32'h5A5A1234);

      // 6: reset during BUSY cancels a pending write.
      txn(1'b1, 32'h20, 32'h11112222, 4'hF, 0, obs);
      @(negedge clk);
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_addr  = 32'h20;
      req_wdata = 32'h12345678;
      req_be    = 4'hF;
      @(negedge clk);
      req_valid = 1'b0;
      rst       = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check($sformatf("t6_rst_rsp_valid[%0d]", i), 32'(rsp_valid), 32'(0));
      end
      rst = 1'b1;
      for (int i = 0; i < LATENCY + 2; i++) begin
         @(negedge clk);
         check($sformatf("t6_post_rsp_valid[%0d]", i), 32'(rsp_valid), 32'(0));
      end
      txn(1'b0, 32'h20, 32'h0, 4'hF, 0, obs);
      check("t6_read_old", obs, 32'h11112222);

      // Randomized traffic against the model.
      for (int t = 0; t < 80; t++) begin
         sel = $urandom_range(0, 9);
         if (sel == 0)      addr = 32'($urandom_range(0, 63) * 4 + $urandom_range(1, 3));
         else if (sel == 1) addr = 32'($urandom_range(1, 4000) * 256 + $urandom_range(0, 255));
         else               addr = 32'($urandom_range(0, 63) * 4);
         txn(1'($urandom_range(0, 1)), addr, $urandom, 4'($urandom_range(0, 15)),
             $urandom_range(0, 3), obs);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
Memory-side responder for the core's load/store port. It implements the slave end of a valid/ready request/response interface, with one transaction outstanding at a time. It holds a byte-addressed little-endian word store, adds a programmable number of wait states, and applies byte enables. Aligned in-range accesses complete normally; misaligned or out-of-range accesses are flagged as errors.

Parameters:
ADDRESS_WIDTH, 32, width of req_addr
DATA_WIDTH, 32, word width. Fixed at 32. Byte-enable width is DATA_WIDTH/8 = 4.
MEM_ADDR_WIDTH, 8, byte-address bits backed by storage. Depth = 2^MEM_ADDR_WIDTH bytes (64 words).
LATENCY, 2, accept-to-response delay in cycles. Minimum 1; elaboration error if 0.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low
req_valid  in  1  request present
req_ready  out  1  responder can accept a request
req_we  in  1  1 = write, 0 = read
req_addr  in  ADDRESS_WIDTH  byte address
req_wdata  in  DATA_WIDTH  write data
req_be  in  DATA_WIDTH/8  byte enables; bit i selects byte i = data[8i+7:8i]
rsp_valid  out  1  response present
rsp_ready  in  1  requester accepts response
rsp_rdata  out  DATA_WIDTH  read data (0 for writes and errors)
rsp_err  out  1  access error flag

Behaviour:
- Reset: while rst=0, force state IDLE with req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, and the wait counter at 0. Storage contents are not reset. First cycle after rst deasserts: req_ready=1.
- States: IDLE, BUSY, RESP. req_ready = (state==IDLE) and reset is deasserted. rsp_valid = (state==RESP).
- IDLE: on an edge with req_valid & req_ready:
  - latch we, addr, wdata, be;
  - load counter = LATENCY-1;
  - go to BUSY.
  - req_* inputs are ignored in all other states.
- BUSY:
  - counter != 0: decrement.
  - counter == 0: on the next edge perform the access, register rsp_rdata/rsp_err, and go to RESP.
  - Result: rsp_valid first visible LATENCY edges after the accept edge.
- Error check: err = (addr[1:0] != 0) OR (addr[ADDRESS_WIDTH-1:MEM_ADDR_WIDTH] != 0).
- Write, no error: bytes with be=1 written at word addr[MEM_ADDR_WIDTH-1:2]; other bytes unchanged. rsp_rdata=0.
- Write, error: storage untouched, rsp_err=1.
- be=0 write: no storage change, rsp_err=0.
- Read, no error: rsp_rdata = stored word with bytes whose be=0 forced to 0.
- Read, error: rsp_rdata=0, rsp_err=1.
- RESP:
  - rsp_valid, rsp_rdata and rsp_err hold stable until an edge with rsp_ready=1.
  - On that edge go to IDLE. req_ready is 1 in the following cycle.
  - No request is accepted on the response-handshake edge: minimum issue spacing is LATENCY+2 cycles.
- rsp_ready is ignored outside RESP.
- Reset mid-operation: asserting rst in BUSY drops the transaction. A write not yet committed never commits. Asserting rst in RESP discards the response. Storage writes happen only on the BUSY→RESP edge.
- Counter width: $clog2(LATENCY)+1 bits. No wrap: it is reloaded only on accept.
- Storage is synchronous-write, registered-read. No read-during-write hazard, since there is one access per transaction.

Test Plan:
1. Hold rst=0 for 3 cycles with req_valid=1 → req_ready=0 and rsp_valid=0 throughout. Release rst → req_ready=1 next cycle, and a request is accepted on the following edge.
2. LATENCY=2: write 0xDEADBEEF to 0x10 with be=4'hF, rsp_ready=1 → rsp_valid rises exactly 2 edges after accept, rsp_err=0, rsp_rdata=0. Then read 0x10 with be=4'hF → rsp_rdata=0xDEADBEEF, rsp_err=0.
3. Write 0x0000AA00 to 0x10 with be=4'b0010 → ack err=0. Read 0x10 with be=4'hF → 0xDEADAAEF. Read 0x10 with be=4'b0011 → 0x0000AAEF.
4. Backpressure: read 0x10 with rsp_ready=0 for 5 cycles → rsp_valid=1 with rsp_rdata stable at 0xDEADAAEF, req_ready=0, and a concurrent req_valid is not accepted. Raise rsp_ready → IDLE next cycle.
5. Errors: read 0x13 → rsp_err=1, rsp_rdata=0. Write 0xFFFFFFFF to 0x100 → rsp_err=1. Read 0x00 → prior value unchanged, err=0.
6. Write 0x12345678 to 0x20, then pull rst low one cycle after accept (in BUSY) → rsp_valid never asserts. After release, read 0x20 → pre-existing value, not 0x12345678.
